cr_ahb2apb_bridge: RTL and testbench
====================================

// Module: cr_ahb2apb_bridge
// PURPOSE
//  AHB-Lite slave (responder) to APB4 master (initiator) bridge on the AHB_INF/APB_INF pair of the top interface.
//  Accepts single AHB transfers, runs each as an APB SETUP/ACCESS sequence and returns read data/response to AHB.
//  Decodes NUM_SLV APB targets from the captured address. One transfer in flight; AHB wait-stated by hreadyout.
// PARAMETERS
//  ADDR_W   32  AHB/APB address width
//  NUM_SLV  4   APB targets (one-hot psel); must be power of 2, >=2
//  SEL_LSB  12  LSB of psel index field: idx = haddr[SEL_LSB +: $clog2(NUM_SLV)]
//  (data width fixed at 32)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  hsel       in   1        AHB slave select
//  haddr      in   ADDR_W   AHB address
//  htrans     in   2        AHB transfer type (IDLE=00 BUSY=01 NONSEQ=10 SEQ=11)
//  hwrite     in   1        1=write
//  hsize      in   3        0=byte 1=half 2=word; >2 treated as word
//  hwdata     in   32       write data (data phase)
//  hready_in  in   1        bus-level HREADY
//  hreadyout  out  1        slave ready
//  hresp      out  1        0=OKAY 1=ERROR
//  hrdata     out  32       read data
//  paddr      out  ADDR_W   APB address (registered)
//  psel       out  NUM_SLV  one-hot APB select
//  penable    out  1        APB access phase
//  pwrite     out  1        APB direction
//  pwdata     out  32       APB write data
//  pstrb      out  4        APB byte strobes (writes only; 0 on reads)
//  prdata     in   32       APB read data
//  pready     in   1        APB ready
//  pslverr    in   1        APB error (used only with CR_AHB2APB_PSLVERR_EN)
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE; hreadyout=1, hresp=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0.
//  Capture: when hsel & htrans[1] & hready_in in IDLE, or in ACCESS on the completing cycle, or in ERR2 ->
//    haddr/hwrite/hsize/psel index are registered and the FSM enters SETUP next cycle.
//  htrans IDLE/BUSY or hsel=0: no capture, zero-wait OKAY (hreadyout=1).
//  SETUP: psel[idx]=1, penable=0, hreadyout=0; pwdata<=hwdata (data phase now valid); pstrb computed -> ACCESS.
//  ACCESS: penable=1, psel held; hreadyout=pready (comb.); hrdata=prdata (comb.) while in ACCESS.
//    pready=0: stay in ACCESS, all APB outputs stable.
//    pready=1 & no error: transfer completes; -> SETUP if new capture this cycle, else IDLE (psel/penable drop).
//  Back-to-back: min 1 AHB wait state per transfer (addr N, SETUP N+1, complete N+2 if pready).
//  pstrb: byte 4'b0001<<haddr[1:0]; half 4'b0011<<{haddr[1],1'b0}; word 4'b1111; reads 4'b0000.
//  hrdata outside ACCESS = 0. hresp=0 outside ERR1/ERR2.
//  States: IDLE, SETUP, ACCESS, ERR1, ERR2 (ERR* only with macro).
// CONFIGURATION
//  `CR_AHB2APB_PSLVERR_EN defined: ACCESS & pready & pslverr -> ERR1 (hresp=1, hreadyout=0, psel/penable=0)
//    -> ERR2 (hresp=1, hreadyout=1) -> SETUP if capture else IDLE. Two-cycle AHB ERROR response.
//  Undefined: pslverr ignored; hresp tied 0; ERR1/ERR2 unreachable and not generated.
// STRUCTURE
//  Package cr_ahb2apb_pkg: state enum (IDLE,SETUP,ACCESS,ERR1,ERR2), HTRANS_* and HSIZE_* localparams, DATA_W=32.
//  Sub-module cr_ahb2apb_strb_gen: combinational hsize/addr[1:0]/hwrite -> pstrb.
//  FSM, capture regs and psel decode live in the top module.
// TESTING
//  Write 0x0000_1004 hsize=2 data 0xDEADBEEF, pready=1 -> psel=4'b0010, pstrb=4'hF, pwdata=0xDEADBEEF, hreadyout low 1 cycle.
//  Read 0x0000_3000, pready low 3 ACCESS cycles then prdata=0x1234_5678 -> psel=4'b1000, hrdata=0x12345678 with hreadyout=1, 4 waits.
//  Byte write addr 0x...2003 data 0xAA000000 -> pstrb=4'b1000; half write addr 0x...0002 -> pstrb=4'b1100.
//  Back-to-back NONSEQ write then read, pready=1 -> second SETUP on cycle after first completes, no IDLE bubble.
//  Macro on: pslverr=1 with pready -> hresp=1 two cycles, hreadyout 0 then 1; macro off: hresp stays 0.
//  Assert rst in ACCESS with pready=0 -> psel/penable=0, hreadyout=1 same cycle; BUSY/IDLE htrans -> no psel.

Source files
------------

// File: rtl/cr_ahb2apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB4 bridge.
// Optional APB error forwarding: CR_AHB2APB_PSLVERR_EN.
package cr_ahb2apb_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    ERR1,
    ERR2
  } state_t;

endpackage

// File: rtl/cr_ahb2apb_strb_gen.sv
// Byte-strobe generator for the AHB2APB bridge.
// Pure combinational; reads always yield an all-zero strobe.
module cr_ahb2apb_strb_gen
  import cr_ahb2apb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  input  logic       hwrite,
  output logic [3:0] pstrb
);

  always_comb begin
    pstrb = 4'b0000;
    if (hwrite) begin
      case (hsize)
        HSIZE_BYTE: pstrb = 4'b0001 << addr_lo;
        HSIZE_HALF: pstrb = 4'b0011 << {addr_lo[1], 1'b0};
        default:    pstrb = 4'b1111;
      endcase
    end
  end

endmodule

// File: rtl/cr_ahb2apb_bridge.sv
// AHB-Lite responder to APB4 initiator bridge, one transfer in flight.
// Define CR_AHB2APB_PSLVERR_EN to forward pslverr as a 2-cycle AHB ERROR.
module cr_ahb2apb_bridge
  import cr_ahb2apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hsel,
  input  logic [ADDR_W-1:0]   haddr,
  input  logic [1:0]          htrans,
  input  logic                hwrite,
  input  logic [2:0]          hsize,
  input  logic [DATA_W-1:0]   hwdata,
  input  logic                hready_in,
  output logic                hreadyout,
  output logic                hresp,
  output logic [DATA_W-1:0]   hrdata,
  output logic [ADDR_W-1:0]   paddr,
  output logic [NUM_SLV-1:0]  psel,
  output logic                penable,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  output logic [3:0]          pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int IDX_W = $clog2(NUM_SLV);

  state_t             state;
  state_t             state_nxt;
  logic               start;
  logic               capture;
  logic [IDX_W-1:0]   idx_q;
  logic [2:0]         size_q;
  logic [NUM_SLV-1:0] sel_dec;
  logic               unused_in;

  assign unused_in = ^{pslverr, htrans[0]};
  assign start = hsel & htrans[1] & hready_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        capture = start;
        if (start) state_nxt = SETUP;
      end
      SETUP: begin
        hreadyout = 1'b0;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        hreadyout = pready;
`ifdef CR_AHB2APB_PSLVERR_EN
        if (pready && pslverr) begin
          hreadyout = 1'b0;
          state_nxt = ERR1;
        end else
`endif
        if (pready) begin
          capture   = start;
          state_nxt = start ? SETUP : IDLE;
        end
      end
`ifdef CR_AHB2APB_PSLVERR_EN
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nxt = ERR2;
      end
      ERR2: begin
        hresp     = 1'b1;
        capture   = start;
        state_nxt = start ? SETUP : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Address-phase fields; held stable through SETUP/ACCESS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      size_q <= '0;
      idx_q  <= '0;
    end else if (capture) begin
      paddr  <= haddr;
      pwrite <= hwrite;
      size_q <= hsize;
      idx_q  <= haddr[SEL_LSB +: IDX_W];
    end
  end

  // hwdata is only valid in the AHB data phase, i.e. during SETUP
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pwdata <= '0;
    else if (state == SETUP) pwdata <= hwdata;
  end

  cr_ahb2apb_strb_gen u_strb (
    .hsize   (size_q),
    .addr_lo (paddr[1:0]),
    .hwrite  (pwrite),
    .pstrb   (pstrb)
  );

  always_comb begin
    sel_dec        = '0;
    sel_dec[idx_q] = 1'b1;
  end

  assign psel    = (state == SETUP || state == ACCESS) ? sel_dec : '0;
  assign penable = (state == ACCESS);
  assign hrdata  = (state == ACCESS) ? prdata : '0;

endmodule

// File: tb/tb_cr_ahb2apb_bridge.sv
// Scoreboard bench for cr_ahb2apb_bridge: random AHB traffic vs a
// transaction-level model; APB and AHB monitors check independently.
module tb_cr_ahb2apb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  wire         hready_in;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic [31:0] paddr;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int errors = 0;
  int checks = 0;

  assign hready_in = hreadyout;
  always #5 clk = ~clk;

  cr_ahb2apb_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hwdata    (hwdata),
    .hready_in (hready_in),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } apb_exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    int          stalls;
    logic        resp;
  } ahb_exp_t;

  typedef struct {
    int          waits;
    logic [31:0] rdata;
    logic        err;
  } apb_rsp_t;

  apb_exp_t apb_q[$];
  ahb_exp_t ahb_q[$];
  apb_rsp_t rsp_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_strb(logic wr, logic [2:0] sz,
                                          logic [1:0] a);
    if (!wr) return 4'h0;
    if (sz == 3'd0) return 4'(1 << a);
    if (sz == 3'd1) return 4'(3 << (2 * a[1]));
    return 4'hF;
  endfunction

  // One AHB address phase; the data phase follows on the next call
  task automatic xfer(logic sel, logic [1:0] tr, logic [31:0] a,
                      logic wr, logic [2:0] sz, logic [31:0] wd,
                      int waits, logic [31:0] rd, logic err);
    int n;
    apb_exp_t ea;
    ahb_exp_t eh;
    apb_rsp_t rs;
    hsel   = sel;
    htrans = tr;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    if (sel && tr[1]) begin
      ea = '{a, 4'(1 << a[13:12]), wr, wd, exp_strb(wr, sz, a[1:0])};
      eh = '{wr, rd, 1 + waits + (err ? 2 : 0), err};
      rs = '{waits, rd, err};
      apb_q.push_back(ea);
      ahb_q.push_back(eh);
      rsp_q.push_back(rs);
    end
    n = 0;
    @(negedge clk);
    while (!hreadyout) begin
      n++;
      if (n > 100) begin
        $display("FAIL accept_timeout: hreadyout stuck low");
        $fatal(1, "bridge hung");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    hwdata = wd;
  endtask

  int       cnt = 0;
  apb_rsp_t cur;

  // APB target: response latency and data come from the stimulus queue
  always @(posedge clk) begin
    #1;
    if (rst) begin
      pready  = 1'b0;
      pslverr = 1'b0;
      cnt     = 0;
    end else if (psel != 4'h0 && !penable) begin
      if (rsp_q.size() > 0) cur = rsp_q.pop_front();
      else                  cur = '{0, 32'h0, 1'b0};
      cnt     = cur.waits;
      prdata  = cur.rdata;
      pready  = 1'b0;
      pslverr = 1'b0;
    end else if (penable) begin
      pready  = (cnt == 0);
      pslverr = (cnt == 0) && cur.err;
      if (cnt > 0) cnt--;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
    end
  end

  apb_exp_t ma;

  always @(negedge clk) begin
    if (!rst) begin
      if (penable) check("penable_without_psel", {31'b0, psel == 4'h0}, 0);
      if (psel != 4'h0 && penable && pready) begin
        if (apb_q.size() == 0) begin
          check("unexpected_apb_xfer", {28'b0, psel}, 0);
        end else begin
          ma = apb_q.pop_front();
          check("paddr", paddr, ma.addr);
          check("psel", {28'b0, psel}, {28'b0, ma.sel});
          check("pwrite", {31'b0, pwrite}, {31'b0, ma.wr});
          check("pstrb", {28'b0, pstrb}, {28'b0, ma.strb});
          if (ma.wr) check("pwdata", pwdata, ma.wdata);
        end
      end
    end
  end

  bit       dp = 1'b0;
  int       st = 0;
  ahb_exp_t mh;

  always @(negedge clk) begin
    if (rst) begin
      dp = 1'b0;
      st = 0;
    end else if (dp && !hreadyout) begin
      st++;
    end else begin
      if (dp) begin
        if (ahb_q.size() == 0) begin
          check("unexpected_ahb_done", 1, 0);
        end else begin
          mh = ahb_q.pop_front();
          check("wait_states", st, mh.stalls);
          check("hresp", {31'b0, hresp}, {31'b0, mh.resp});
          if (!mh.wr && !mh.resp) check("hrdata", hrdata, mh.rdata);
        end
      end else begin
        check("idle_hreadyout", {31'b0, hreadyout}, 1);
        check("idle_hresp", {31'b0, hresp}, 0);
      end
      dp = hsel && htrans[1];
      st = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        sel, wr, er;
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [31:0] a;
    int          w;

    rst    = 1'b1;
    hsel   = 1'b0;
    htrans = 2'b00;
    haddr  = '0;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hwdata = '0;
    prdata = '0;
    pready = 1'b0;
    pslverr = 1'b0;
    #3;
    check("rst_hreadyout", {31'b0, hreadyout}, 1);
    check("rst_hresp", {31'b0, hresp}, 0);
    check("rst_psel", {28'b0, psel}, 0);
    check("rst_penable", {31'b0, penable}, 0);
    check("rst_pwrite", {31'b0, pwrite}, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pstrb", {28'b0, pstrb}, 0);
    check("rst_hrdata", hrdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    xfer(1, 2'b10, 32'h0000_1004, 1, 3'd2, 32'hDEAD_BEEF, 0, 0, 0);
    xfer(1, 2'b10, 32'h0000_3000, 0, 3'd2, 32'h0, 3, 32'h1234_5678, 0);
    xfer(1, 2'b10, 32'h0000_2003, 1, 3'd0, 32'hAA00_0000, 0, 0, 0);
    xfer(1, 2'b10, 32'h0000_0002, 1, 3'd1, 32'h5566_0000, 1, 0, 0);
    xfer(1, 2'b10, 32'h0000_1008, 1, 3'd2, 32'h0BAD_F00D, 0, 0, 0);
    xfer(1, 2'b10, 32'h0000_2010, 0, 3'd2, 32'h0, 0, 32'hCAFE_F00D, 0);
    xfer(1, 2'b00, 32'h0000_1000, 1, 3'd2, 32'h1111_1111, 0, 0, 0);
    xfer(1, 2'b01, 32'h0000_2000, 1, 3'd2, 32'h2222_2222, 0, 0, 0);
    xfer(0, 2'b10, 32'h0000_3000, 1, 3'd2, 32'h3333_3333, 0, 0, 0);
    xfer(1, 2'b11, 32'h0000_0101, 1, 3'd0, 32'h4444_4444, 2, 0, 0);
`ifdef CR_AHB2APB_PSLVERR_EN
    xfer(1, 2'b10, 32'h0000_1000, 1, 3'd2, 32'h5555_5555, 0, 0, 1);
    xfer(1, 2'b10, 32'h0000_2000, 0, 3'd2, 32'h0, 2, 32'h7777, 1);
`endif
    xfer(0, 2'b00, 32'h0, 0, 3'd0, 32'h0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      sel = ($urandom_range(0, 7) != 0);
      tr  = 2'($urandom);
      a   = $urandom;
      wr  = 1'($urandom);
      sz  = 3'($urandom);
      w   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 0;
`ifdef CR_AHB2APB_PSLVERR_EN
      er  = ($urandom_range(0, 5) == 0);
`else
      er  = 1'b0;
`endif
      xfer(sel, tr, a, wr, sz, $urandom, w, $urandom, er);
    end
    xfer(0, 2'b00, 32'h0, 0, 3'd0, 32'h0, 0, 0, 0);
    repeat (10) @(negedge clk);
    check("apb_q_drained", apb_q.size(), 0);
    check("ahb_q_drained", ahb_q.size(), 0);

    // Reset while stalled in ACCESS
    begin
      apb_rsp_t rs;
      rs = '{8, 32'h0, 1'b0};
      rsp_q.push_back(rs);
    end
    @(posedge clk);
    #1;
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = 32'h0000_2000;
    hwrite = 1'b0;
    @(posedge clk);
    #1;
    hsel   = 1'b0;
    htrans = 2'b00;
    @(posedge clk);
    #2;
    check("pre_rst_penable", {31'b0, penable}, 1);
    check("pre_rst_hreadyout", {31'b0, hreadyout}, 0);
    rst = 1'b1;
    #1;
    check("async_rst_psel", {28'b0, psel}, 0);
    check("async_rst_penable", {31'b0, penable}, 0);
    check("async_rst_hreadyout", {31'b0, hreadyout}, 1);
    check("async_rst_paddr", paddr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_q.delete();
    apb_q.delete();
    ahb_q.delete();
    xfer(1, 2'b10, 32'h0000_3004, 1, 3'd0, 32'h0000_9900, 1, 0, 0);
    xfer(0, 2'b00, 32'h0, 0, 3'd0, 32'h0, 0, 0, 0);
    repeat (6) @(negedge clk);
    check("post_rst_drained", apb_q.size() + ahb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
